// File: rtl/spi_slave_rx.sv
// SPI receive capture: synchronizes an externally clocked SPI stream
// (CPOL=0, MSB first), assembles PACKET_SIZE-bit words and queues them
// in a small first-word-fall-through FIFO with frame-start tagging.
module spi_slave_rx #(
  parameter int PACKET_SIZE    = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int SAMPLE_ON_FALL = 1
) (
  input  logic                          iclk,
  input  logic                          reset,
  input  logic                          CLK,
  input  logic                          SS,
  input  logic                          SDO,
  output logic [PACKET_SIZE-1:0]        out_data,
  output logic                          out_first,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fill,
  output logic                          busy,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(PACKET_SIZE + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(PACKET_SIZE - 1);
  localparam logic [PW:0]   FULL_CNT = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} state_t;

  // Synchronizer chains: bit 0 is the first flop, bit 1 the synced value,
  // bit 2 the previous synced value used for edge detection.
  logic [2:0] clk_sync_q;
  logic [2:0] ss_sync_q;
  logic [1:0] sdo_sync_q;

  logic clk_rise, clk_fall, samp_edge, ss_fall, ss_rise, sdo_s;

  state_t     state_q, state_d;
  logic [1:0] settle_q;

  logic start_frame, end_frame, take_bit;

  logic [CW-1:0]          bit_cnt_q;
  logic                   first_pend_q;
  logic                   wr_req_q;
  logic                   frame_err_q;
  logic [PACKET_SIZE-1:0] shift_q;
  logic [PACKET_SIZE-1:0] wr_word_q;
  logic                   wr_first_q;

  logic [PACKET_SIZE:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [PW:0]            cnt_q;
  logic                   overflow_q;
  logic                   push, pop, full;
  logic [PACKET_SIZE:0]   head;

  // Bring the asynchronous SPI pins into the iclk domain, idle values on reset
  always_ff @(posedge iclk) begin
    if (reset) begin
      clk_sync_q <= 3'b000;
      ss_sync_q  <= 3'b111;
      sdo_sync_q <= 2'b00;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], CLK};
      ss_sync_q  <= {ss_sync_q[1:0], SS};
      sdo_sync_q <= {sdo_sync_q[0], SDO};
    end
  end

  assign clk_rise  = clk_sync_q[1] & ~clk_sync_q[2];
  assign clk_fall  = ~clk_sync_q[1] & clk_sync_q[2];
  assign samp_edge = (SAMPLE_ON_FALL != 0) ? clk_fall : clk_rise;
  assign ss_fall   = ~ss_sync_q[1] & ss_sync_q[2];
  assign ss_rise   = ss_sync_q[1] & ~ss_sync_q[2];
  assign sdo_s     = sdo_sync_q[1];

  // State register; settle_q lets the synchronizers flush their reset
  // values before SS is trusted, so a frame in flight at reset is skipped.
  always_ff @(posedge iclk) begin
    if (reset) begin
      state_q  <= WAIT_IDLE;
      settle_q <= 2'd0;
    end else begin
      state_q <= state_d;
      if (state_q == WAIT_IDLE && settle_q != 2'd3) settle_q <= settle_q + 2'd1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_IDLE: if (settle_q == 2'd3 && ss_sync_q[1]) state_d = IDLE;
      IDLE:      if (ss_fall) state_d = ACTIVE;
      ACTIVE:    if (ss_rise) state_d = IDLE;
      default:   state_d = WAIT_IDLE;
    endcase
  end

  // FSM outputs; an SS release in the same cycle as a sample edge wins
  always_comb begin
    busy        = (state_q == ACTIVE);
    start_frame = (state_q == IDLE) & ss_fall;
    end_frame   = (state_q == ACTIVE) & ss_rise;
    take_bit    = (state_q == ACTIVE) & samp_edge & ~ss_rise;
  end

  // Bit counting, frame-start tracking, write request and frame error pulse
  always_ff @(posedge iclk) begin
    if (reset) begin
      bit_cnt_q    <= '0;
      first_pend_q <= 1'b0;
      wr_req_q     <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      wr_req_q    <= 1'b0;
      frame_err_q <= 1'b0;
      if (start_frame) begin
        bit_cnt_q    <= '0;
        first_pend_q <= 1'b1;
      end else if (end_frame) begin
        frame_err_q <= (bit_cnt_q != '0);
        bit_cnt_q   <= '0;
      end else if (take_bit) begin
        if (bit_cnt_q == LAST_BIT) begin
          wr_req_q     <= 1'b1;
          bit_cnt_q    <= '0;
          first_pend_q <= 1'b0;
        end else begin
          bit_cnt_q <= bit_cnt_q + CW'(1);
        end
      end
    end
  end

  // Shift register and the staged word handed to the FIFO next cycle
  always_ff @(posedge iclk) begin
    if (start_frame) begin
      shift_q <= '0;
    end else if (take_bit) begin
      shift_q <= {shift_q[PACKET_SIZE-2:0], sdo_s};
      if (bit_cnt_q == LAST_BIT) begin
        wr_word_q  <= {shift_q[PACKET_SIZE-2:0], sdo_s};
        wr_first_q <= first_pend_q;
      end
    end
  end

  assign full = (cnt_q == FULL_CNT);
  assign pop  = (cnt_q != '0) & out_ready;
  assign push = wr_req_q & (~full | pop);

  // FIFO storage
  always_ff @(posedge iclk) begin
    if (push) mem_q[wr_ptr_q] <= {wr_first_q, wr_word_q};
  end

  // FIFO pointers, occupancy and overflow pulse
  always_ff @(posedge iclk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (PW + 1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW + 1)'(1);
        default: cnt_q <= cnt_q;
      endcase
      overflow_q <= wr_req_q & full & ~pop;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign out_valid = (cnt_q != '0);
  assign out_data  = out_valid ? head[PACKET_SIZE-1:0] : '0;
  assign out_first = out_valid & head[PACKET_SIZE];
  assign fill      = cnt_q;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
SPI receive-side capture block. It samples the CLK/SS/SDO lines driven by the ADC-style SPI master (CPOL=0, MSB first, data launched on CLK rising edge), all asynchronous to iclk. It assembles PACKET_SIZE-bit words and queues them in a small FIFO. A valid/ready stream presents the words to downstream logic, with per-word frame-start tagging and error/overflow pulses.

Parameters:
PACKET_SIZE, 8, bits per word.
FIFO_DEPTH, 4, word entries; power of two, at least 2.
SAMPLE_ON_FALL, 1, 1 = sample SDO on CLK falling edge; 0 = on rising edge.

Ports:
iclk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
CLK  input  1  SPI serial clock, asynchronous to iclk, idle 0.
SS  input  1  slave select, active low, idle 1.
SDO  input  1  serial data from the ADC, MSB first.
out_data  output  PACKET_SIZE  head-of-FIFO word.
out_first  output  1  head word was the first word of its SS frame.
out_valid  output  1  FIFO non-empty.
out_ready  input  1  consumer accepts the head word when out_valid & out_ready.
fill  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
busy  output  1  high in ACTIVE state.
frame_err  output  1  one-cycle pulse: SS deasserted with a partial word.
overflow  output  1  one-cycle pulse: complete word dropped because the FIFO was full.

Behaviour:
- Input conditioning: 2-FF synchronizer on CLK, SS and SDO. Synchronizer and edge-detect registers reset to idle values (CLK=0, SS=1, SDO=0). A third register on CLK and SS provides edge detection.
- Timing requirement on the source: each CLK high and low phase, and SS setup/hold to CLK, lasts at least 3 iclk periods. Faster input gives undefined results; no detection is attempted.
- Sample edge is the synced CLK falling edge (rising if SAMPLE_ON_FALL=0). SDO is taken from the same synchronizer stage as CLK.
- FSM states:
  - WAIT_IDLE (reset state): go to IDLE once synced SS=1. A frame already in progress at reset release is therefore never captured.
  - IDLE: go to ACTIVE on synced SS falling edge; clear bit_cnt and shift register, set first_pend=1.
  - ACTIVE: on each sample edge, shift_reg <= {shift_reg[PACKET_SIZE-2:0], sdo_s} and increment bit_cnt. When the PACKET_SIZE-th bit is sampled:
    - issue a FIFO write of {first_pend, word};
    - reset bit_cnt to 0 and clear first_pend.
  - ACTIVE: on synced SS rising edge, go to IDLE. If bit_cnt != 0, pulse frame_err and discard the partial word.
  - If an SS rising edge and a sample edge are seen in the same cycle, the SS edge wins and the sample is ignored.
- CLK edges while not ACTIVE are ignored.
- FIFO:
  - First-word-fall-through; out_data/out_first are valid whenever out_valid=1.
  - A write in the cycle after the final sample edge is detected makes out_valid=1 in the following cycle when the FIFO was empty. Latency from the pin-level final CLK edge to out_valid is 4-5 iclk cycles.
  - Pop when out_valid & out_ready.
  - Write when full: word dropped and overflow pulses, unless a pop occurs in the same cycle, in which case the write is accepted.
  - Pop when empty: no effect.
  - fill updates the cycle after push/pop; simultaneous push+pop leaves it unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset values: out_valid=0, out_first=0, out_data=0, fill=0, busy=0, frame_err=0, overflow=0; FSM in WAIT_IDLE; FIFO pointers 0. Reset mid-frame discards all state, including queued words.

Test Plan:
- Single frame: SS low, byte 0x2A, SS high, out_ready=1 -> exactly one word, out_data=0x2A, out_first=1, frame_err=0, busy returns to 0.
- ADC message stream: 15 one-byte frames 126,0,21,75,29,11,7,119,118,10,17,5,12,8,42 with out_ready=1 -> 15 words received in that order, each with out_first=1, no error or overflow pulses.
- Multi-word frame: 3 bytes 0x81,0x7E,0xFF under one SS low -> out_first sequence 1,0,0; data matches.
- Partial frame: 5 CLK pulses then SS high -> frame_err pulses once, fill stays 0; next full frame with 0x55 is received correctly.
- Overflow with FIFO_DEPTH=4 and out_ready=0: 6 one-byte frames 1..6 -> fill=4, overflow pulses twice; then out_ready=1 drains 1,2,3,4.
- Reset mid-frame: assert reset after 3 bits while SS is held low -> no word and no frame_err for that frame; the block waits for SS high, and the next frame's byte 0x3C is received with out_first=1.
